// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - diagonal-skew lane feeder for the PE array edge, tile framed by I_LAST or K beats
// Optional O_CLR per-lane tile-start marker when SA_FEEDER_CLR_EN is defined.
module sa_skew_feeder #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int K  = 8
) (
   input  logic            I_CLK,
   input  logic            I_RST_N,
   input  logic            I_VLD,
   output logic            O_RDY,
   input  logic [N*DW-1:0] I_DATA,
   input  logic            I_LAST,
   output logic [N*DW-1:0] O_X,
   output logic [N-1:0]    O_VLD,
`ifdef SA_FEEDER_CLR_EN
   output logic [N-1:0]    O_CLR,
`endif
   output logic            O_BUSY,
   output logic            O_DONE
);

   localparam int CW = $clog2(K + 1);
   localparam int FW = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [CW:0]   cnt_inc;
   logic          accept;
   logic          first_beat;
   logic          rdy_q, busy_q, done_q;

   assign accept     = I_VLD && rdy_q;
   assign first_beat = accept && (state_q == S_IDLE);
   assign cnt_inc    = {1'b0, cnt_q} + (CW + 1)'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         S_IDLE, S_FEED: begin
            if (accept) begin
               cnt_d = cnt_inc[CW-1:0];
               if (I_LAST || (cnt_inc >= (CW + 1)'(K))) begin
                  state_d = S_FLUSH;
                  fcnt_d  = FW'(N - 1);
               end else begin
                  state_d = S_FEED;
               end
            end
         end
         S_FLUSH: begin
            if (fcnt_q == '0) state_d = S_DONE;
            else              fcnt_d  = fcnt_q - FW'(1);
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            fcnt_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they all read 0 while reset is held.
   always_ff @(posedge I_CLK or posedge I_RST_N) begin
      if (I_RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         rdy_q   <= (state_d == S_IDLE) || (state_d == S_FEED);
         busy_q  <= (state_d == S_FEED) || (state_d == S_FLUSH);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign O_RDY  = rdy_q;
   assign O_BUSY = busy_q;
   assign O_DONE = done_q;

   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [g:0]    v_q;
      logic [DW-1:0] d_q [0:g];
`ifdef SA_FEEDER_CLR_EN
      logic [g:0]    c_q;
`endif

      // Non-accept cycles load a zero bubble so O_X is 0 wherever O_VLD is 0.
      always_ff @(posedge I_CLK or posedge I_RST_N) begin
         if (I_RST_N) begin
            v_q <= '0;
            for (int j = 0; j <= g; j++) d_q[j] <= '0;
`ifdef SA_FEEDER_CLR_EN
            c_q <= '0;
`endif
         end else begin
            v_q[0] <= accept;
            d_q[0] <= accept ? I_DATA[g*DW +: DW] : '0;
`ifdef SA_FEEDER_CLR_EN
            c_q[0] <= first_beat;
`endif
            for (int j = 1; j <= g; j++) begin
               v_q[j] <= v_q[j-1];
               d_q[j] <= d_q[j-1];
`ifdef SA_FEEDER_CLR_EN
               c_q[j] <= c_q[j-1];
`endif
            end
         end
      end

      assign O_X[g*DW +: DW] = d_q[g];
      assign O_VLD[g]        = v_q[g];
`ifdef SA_FEEDER_CLR_EN
      assign O_CLR[g]        = c_q[g];
`endif
   end

`ifndef SA_FEEDER_CLR_EN
   logic unused_first;
   assign unused_first = first_beat;
`endif

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb/tb_sa_skew_feeder.sv - randomized and directed bench for sa_skew_feeder against a timestamp model
module tb_sa_skew_feeder;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int K  = 8;

   logic            I_CLK   = 1'b0;
   logic            I_RST_N = 1'b0;
   logic            I_VLD   = 1'b0;
   logic            I_LAST  = 1'b0;
   logic [N*DW-1:0] I_DATA  = '0;
   logic            O_RDY, O_BUSY, O_DONE;
   logic [N*DW-1:0] O_X;
   logic [N-1:0]    O_VLD;
`ifdef SA_FEEDER_CLR_EN
   logic [N-1:0]    O_CLR;
`endif

   sa_skew_feeder #(.N(N), .DW(DW), .K(K)) dut (
      .I_CLK   (I_CLK),
      .I_RST_N (I_RST_N),
      .I_VLD   (I_VLD),
      .O_RDY   (O_RDY),
      .I_DATA  (I_DATA),
      .I_LAST  (I_LAST),
      .O_X     (O_X),
      .O_VLD   (O_VLD),
`ifdef SA_FEEDER_CLR_EN
      .O_CLR   (O_CLR),
`endif
      .O_BUSY  (O_BUSY),
      .O_DONE  (O_DONE)
   );

   always #5 I_CLK = ~I_CLK;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
   endtask

   // Model: every edge is timestamped; lane i shows what was accepted i edges ago.
   logic [N*DW-1:0] ring_d [16];
   logic            ring_v [16];
   logic            ring_f [16];
   int              t      = 0;
   int              term_t = -1000;
   int              m_cnt  = 0;
   logic            m_rdy  = 1'b0;
   logic            m_busy = 1'b0;
   logic            m_done = 1'b0;

   task automatic model_reset();
      for (int k = 0; k < 16; k++) begin
         ring_d[k] = '0; ring_v[k] = 1'b0; ring_f[k] = 1'b0;
      end
      term_t = -1000; m_cnt = 0;
      m_rdy = 1'b0; m_busy = 1'b0; m_done = 1'b0;
   endtask

   task automatic check_outputs();
      logic [N*DW-1:0] ex, row;
      logic [N-1:0]    ev, ec;
      ex = '0; ev = '0; ec = '0;
      for (int i = 0; i < N; i++) begin
         row = ring_d[(t - i) & 15];
         ev[i] = ring_v[(t - i) & 15];
         ec[i] = ring_f[(t - i) & 15];
         ex[i*DW +: DW] = row[i*DW +: DW];
      end
      check("rdy",  64'(O_RDY),  64'(m_rdy));
      check("busy", 64'(O_BUSY), 64'(m_busy));
      check("done", 64'(O_DONE), 64'(m_done));
      check("vld",  64'(O_VLD),  64'(ev));
      check("x",    64'(O_X),    64'(ex));
`ifdef SA_FEEDER_CLR_EN
      check("clr",  64'(O_CLR),  64'(ec));
`else
      if (ec === 'x) $display("ring_f undefined");
`endif
   endtask

   // Drives one cycle; returns whether the model says the beat was accepted.
   task automatic step(input logic v, input logic l, input logic [N*DW-1:0] d, output logic acc);
      int idx;
      I_VLD = v; I_LAST = l; I_DATA = d;
      acc = v && m_rdy;
      @(posedge I_CLK);
      t++;
      idx = t & 15;
      ring_v[idx] = acc;
      ring_d[idx] = acc ? d : '0;
      ring_f[idx] = acc && (m_cnt == 0);
      if (acc) begin
         m_cnt++;
         if (l || m_cnt == K) begin
            term_t = t;
            m_cnt  = 0;
         end
      end
      m_rdy  = !(t >= term_t && t <= term_t + N);
      m_done = (t == term_t + N);
      m_busy = (m_cnt > 0) || (t >= term_t && t < term_t + N);
      @(negedge I_CLK);
      check_outputs();
   endtask

   function automatic logic [N*DW-1:0] mk(input int b);
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(16'h1000 * (b + 1) + i);
      return r;
   endfunction

   task automatic apply_reset();
      I_RST_N = 1'b1;
      #1;
      check("rst_vld",  64'(O_VLD),  64'(0));
      check("rst_x",    64'(O_X),    64'(0));
      check("rst_rdy",  64'(O_RDY),  64'(0));
      check("rst_done", 64'(O_DONE), 64'(0));
      check("rst_busy", 64'(O_BUSY), 64'(0));
      @(posedge I_CLK);
      @(negedge I_CLK);
      I_RST_N = 1'b0;
      model_reset();
   endtask

   logic a;
   logic            hold;
   logic            p_last;
   logic [N*DW-1:0] p_data;

   initial begin
      model_reset();
      #2;
      apply_reset();

      // Three back-to-back beats, last on the third, then drain.
      for (int b = 0; b < 3; b++) step(1'b1, b == 2, mk(b), a);
      for (int c = 0; c < N + 3; c++) step(1'b0, 1'b0, '0, a);

      // Same stream with a one-cycle gap after the first beat.
      step(1'b1, 1'b0, mk(0), a);
      step(1'b0, 1'b0, '0, a);
      step(1'b1, 1'b0, mk(1), a);
      step(1'b1, 1'b1, mk(2), a);
      for (int c = 0; c < N + 3; c++) step(1'b0, 1'b0, '0, a);

      // K beats without last, a ninth held through flush with BEEF data.
      for (int b = 0; b < K; b++) step(1'b1, 1'b0, mk(b), a);
      hold = 1'b1;
      for (int c = 0; c < 3 * N && hold; c++) begin
         step(1'b1, 1'b0, {N{16'hBEEF}}, a);
         if (a) hold = 1'b0;
      end
      check("held_beat_accepted", 64'(hold), 64'(0));
      for (int c = 0; c < N + 3; c++) step(1'b0, 1'b1, '0, a);

      // Reset while lane 2 holds a valid beat.
      for (int b = 0; b < 3; b++) step(1'b1, 1'b0, mk(b), a);
      apply_reset();
      for (int c = 0; c < N + 3; c++) step(1'b0, 1'b0, '0, a);

      // Two 2-beat tiles back to back for the tile-start marker.
      for (int tile = 0; tile < 2; tile++) begin
         step(1'b1, 1'b0, mk(4 * tile), a);
         step(1'b1, 1'b1, mk(4 * tile + 1), a);
         for (int c = 0; c < N + 1; c++) step(1'b0, 1'b0, '0, a);
      end
      for (int c = 0; c < 2; c++) step(1'b0, 1'b0, '0, a);

      // Random source that holds a beat once it offers it.
      hold = 1'b0;
      p_data = '0; p_last = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!hold) begin
            p_data = {$urandom, $urandom};
            p_last = ($urandom_range(0, 4) == 0);
            hold   = ($urandom_range(0, 3) != 0);
         end
         step(hold, p_last, hold ? p_data : {$urandom, $urandom}, a);
         if (a) hold = 1'b0;
         if (c % 997 == 500) apply_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
